// File: rtl/coin_acceptor_if.sv
// Coin acceptor bus: raw sensors and consumer hold in, coin code and status out.
// Audit counters exist only when COIN_AUDIT_EN is defined.
interface coin_acceptor_if;
    logic [2:0] sense;
    logic       hold;
    logic [1:0] i;
    logic       coin_valid;
    logic       reject;
    logic       jam;
`ifdef COIN_AUDIT_EN
    logic [7:0] cnt_a;
    logic [7:0] cnt_b;
    logic [7:0] cnt_c;
    logic [7:0] cnt_rej;

    modport master (input sense, hold,
                    output i, coin_valid, reject, jam, cnt_a, cnt_b, cnt_c, cnt_rej);
    modport slave  (output sense, hold,
                    input i, coin_valid, reject, jam, cnt_a, cnt_b, cnt_c, cnt_rej);
`else
    modport master (input sense, hold, output i, coin_valid, reject, jam);
    modport slave  (output sense, hold, input i, coin_valid, reject, jam);
`endif
endinterface

// File: rtl/coin_acceptor.sv
// Coin sensor front end: synchronise, debounce, classify and emit one coin code per press.
// Optional audit counters are enabled with `define COIN_AUDIT_EN.
module coin_acceptor #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned JAM_CYCLES      = 64,
    parameter int unsigned CNT_W           = 8
) (
    input  logic            clk,
    input  logic            rst,
    coin_acceptor_if.master bus
);
    localparam logic [1:0] IDLE         = 2'd0;
    localparam logic [1:0] DEBOUNCE     = 2'd1;
    localparam logic [1:0] WAIT_RELEASE = 2'd2;

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] JAM_MAX  = CNT_W'(JAM_CYCLES);

    logic [2:0]       s1_q, ss_q;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       pat_q, pat_d;
    logic             slot_v_q, slot_v_d;
    logic [1:0]       slot_code_q, slot_code_d;
    logic [1:0]       i_q, i_d;
    logic             cv_q, cv_d;
    logic             rej_q, rej_d;
    logic             jam_q, jam_d;
    logic             emit;
    logic             onehot;
    logic [1:0]       pat_code;

    always_comb begin
        onehot   = 1'b0;
        pat_code = 2'b00;
        case (pat_q)
            3'b001:  begin onehot = 1'b1; pat_code = 2'b01; end
            3'b010:  begin onehot = 1'b1; pat_code = 2'b10; end
            3'b100:  begin onehot = 1'b1; pat_code = 2'b11; end
            default: begin onehot = 1'b0; pat_code = 2'b00; end
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pat_d       = pat_q;
        slot_v_d    = slot_v_q;
        slot_code_d = slot_code_q;
        i_d         = 2'b00;
        cv_d        = 1'b0;
        rej_d       = 1'b0;
        jam_d       = jam_q;
        emit        = slot_v_q && !bus.hold;

        if (emit) begin
            i_d      = slot_code_q;
            cv_d     = 1'b1;
            slot_v_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (ss_q != 3'b000) begin
                    pat_d   = ss_q;
                    cnt_d   = '0;
                    state_d = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (ss_q != pat_q) begin
                    state_d = IDLE;
                end else if (cnt_q == DEB_LAST) begin
                    // A slot being emitted this edge counts as free for the new coin.
                    if (onehot && (!slot_v_q || emit)) begin
                        slot_v_d    = 1'b1;
                        slot_code_d = pat_code;
                    end else begin
                        rej_d = 1'b1;
                    end
                    cnt_d   = '0;
                    state_d = WAIT_RELEASE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT_RELEASE: begin
                if (ss_q == 3'b000) begin
                    state_d = IDLE;
                    jam_d   = 1'b0;
                end else begin
                    cnt_d = (cnt_q >= JAM_MAX) ? cnt_q : cnt_q + CNT_W'(1);
                    jam_d = (cnt_d >= JAM_MAX);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q        <= '0;
            ss_q        <= '0;
            state_q     <= IDLE;
            cnt_q       <= '0;
            pat_q       <= '0;
            slot_v_q    <= 1'b0;
            slot_code_q <= '0;
            i_q         <= '0;
            cv_q        <= 1'b0;
            rej_q       <= 1'b0;
            jam_q       <= 1'b0;
        end else begin
            s1_q        <= bus.sense;
            ss_q        <= s1_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pat_q       <= pat_d;
            slot_v_q    <= slot_v_d;
            slot_code_q <= slot_code_d;
            i_q         <= i_d;
            cv_q        <= cv_d;
            rej_q       <= rej_d;
            jam_q       <= jam_d;
        end
    end

    assign bus.i          = i_q;
    assign bus.coin_valid = cv_q;
    assign bus.reject     = rej_q;
    assign bus.jam        = jam_q;

`ifdef COIN_AUDIT_EN
    logic [7:0] cnt_a_q, cnt_b_q, cnt_c_q, cnt_rej_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_a_q   <= '0;
            cnt_b_q   <= '0;
            cnt_c_q   <= '0;
            cnt_rej_q <= '0;
        end else begin
            if (cv_d && i_d == 2'b01 && cnt_a_q != '1) cnt_a_q <= cnt_a_q + 8'd1;
            if (cv_d && i_d == 2'b10 && cnt_b_q != '1) cnt_b_q <= cnt_b_q + 8'd1;
            if (cv_d && i_d == 2'b11 && cnt_c_q != '1) cnt_c_q <= cnt_c_q + 8'd1;
            if (rej_d && cnt_rej_q != '1)              cnt_rej_q <= cnt_rej_q + 8'd1;
        end
    end

    assign bus.cnt_a   = cnt_a_q;
    assign bus.cnt_b   = cnt_b_q;
    assign bus.cnt_c   = cnt_c_q;
    assign bus.cnt_rej = cnt_rej_q;
`endif
endmodule
